// File: rtl/dcache_tl_d_scope_capture_pkg.sv
// Shared definitions for the dcache TileLink D-channel scope capture:
// D opcodes, the default-width capture record and beat-count helpers.
package dcache_scope_pkg;

  typedef enum logic [2:0] {
    TL_ACCESS_ACK      = 3'd0,
    TL_ACCESS_ACK_DATA = 3'd1,
    TL_HINT_ACK        = 3'd2,
    TL_GRANT           = 3'd4,
    TL_GRANT_DATA      = 3'd5,
    TL_RELEASE_ACK     = 3'd6
  } tl_d_opcode_e;

  localparam int unsigned SCOPE_DATA_W   = 64;
  localparam int unsigned SCOPE_SOURCE_W = 4;
  localparam int unsigned SCOPE_SINK_W   = 3;
  localparam int unsigned SCOPE_TS_W     = 16;

  // Record as seen by the scope bundle at the default widths.
  typedef struct packed {
    logic [2:0]                opcode;
    logic [1:0]                param;
    logic [SCOPE_SOURCE_W-1:0] source;
    logic [SCOPE_SINK_W-1:0]   sink;
    logic                      denied;
    logic                      corrupt;
    logic [7:0]                beat;
    logic                      last;
    logic [SCOPE_TS_W-1:0]     ts;
    logic [SCOPE_DATA_W-1:0]   data;
  } scope_rec_t;

  function automatic logic is_data_opcode(input logic [2:0] op);
    return (op == TL_ACCESS_ACK_DATA) || (op == TL_GRANT_DATA);
  endfunction

  // Index of the final beat of a message; lg_bytes = log2(bytes per beat).
  function automatic logic [15:0] beat_last_idx(input logic [2:0]  op,
                                                input logic [3:0]  size,
                                                input int unsigned lg_bytes);
    logic [15:0] idx;
    idx = '0;
    if (is_data_opcode(op) && (32'(size) > lg_bytes)) begin
      idx = 16'((32'd1 << (32'(size) - lg_bytes)) - 32'd1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dcache_tl_d_scope_capture_if.sv
// Snooped TileLink D beat plus the record drain port of the scope capture.
// master: the side driving D and consuming records; slave: the capture block.
interface dcache_tl_d_scope_capture_if #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned SOURCE_W = 4,
  parameter int unsigned SINK_W   = 3,
  parameter int unsigned TS_W     = 16
);

  logic                d_valid;
  logic                d_ready;
  logic [2:0]          d_opcode;
  logic [1:0]          d_param;
  logic [3:0]          d_size;
  logic [SOURCE_W-1:0] d_source;
  logic [SINK_W-1:0]   d_sink;
  logic                d_denied;
  logic                d_corrupt;
  logic [DATA_W-1:0]   d_data;

  logic                rec_valid;
  logic                rec_ready;
  logic [2:0]          rec_opcode;
  logic [1:0]          rec_param;
  logic [SOURCE_W-1:0] rec_source;
  logic [SINK_W-1:0]   rec_sink;
  logic                rec_denied;
  logic                rec_corrupt;
  logic [7:0]          rec_beat;
  logic                rec_last;
  logic [TS_W-1:0]     rec_ts;
  logic [DATA_W-1:0]   rec_data;

  modport master (
    output d_valid, d_ready, d_opcode, d_param, d_size, d_source, d_sink,
           d_denied, d_corrupt, d_data, rec_ready,
    input  rec_valid, rec_opcode, rec_param, rec_source, rec_sink,
           rec_denied, rec_corrupt, rec_beat, rec_last, rec_ts, rec_data
  );

  modport slave (
    input  d_valid, d_ready, d_opcode, d_param, d_size, d_source, d_sink,
           d_denied, d_corrupt, d_data, rec_ready,
    output rec_valid, rec_opcode, rec_param, rec_source, rec_sink,
           rec_denied, rec_corrupt, rec_beat, rec_last, rec_ts, rec_data
  );

endinterface

// File: rtl/dcache_tl_d_scope_capture_fifo.sv
// scope_rec_fifo: synchronous record FIFO with flush; read data is forced to
// zero while empty so the drain port shows clean fields after reset/flush.
module scope_rec_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when indices match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = ((wr_q ^ rd_q) == {1'b1, {AW{1'b0}}});

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + (AW+1)'(1);
      if (do_pop)  rd_d = rd_q + (AW+1)'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // NOTE: storage is not reset; the pointers define validity and empty masks the read port.
  always_ff @(posedge clock_i) begin
    if (do_push && !flush_i) begin
      mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/dcache_tl_d_scope_capture.sv
// Passive D-channel scope capture: tracks beats, timestamps fires, filters by
// opcode and queues records for the scope drain; drops are counted, never stalled.
module dcache_tl_d_scope_capture
  import dcache_scope_pkg::*;
#(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned SOURCE_W = 4,
  parameter int unsigned SINK_W   = 3,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned TS_W     = 16
) (
  input  logic                       clock_i,
  input  logic                       reset_n_i,
  dcache_tl_d_scope_capture_if.slave tl_if,
  input  logic                       cap_en_i,
  input  logic [7:0]                 opcode_mask_i,
  input  logic                       clear_i,
  output logic [7:0]                 drop_cnt_o,
  output logic                       overflow_o
);

  localparam int unsigned LG_BYTES = $clog2(DATA_W / 8);

  typedef struct packed {
    logic [2:0]          opcode;
    logic [1:0]          param;
    logic [SOURCE_W-1:0] source;
    logic [SINK_W-1:0]   sink;
    logic                denied;
    logic                corrupt;
    logic [7:0]          beat;
    logic                last;
    logic [TS_W-1:0]     ts;
    logic [DATA_W-1:0]   data;
  } rec_t;

  localparam int unsigned REC_W = $bits(rec_t);

  logic        fire;
  logic        is_last;
  logic [15:0] last_idx;
  logic [7:0]  beat_q, beat_d;
  logic [TS_W-1:0] ts_q;
  logic [7:0]  drop_q, drop_d;
  logic        ovf_q, ovf_d;

  logic        cand;
  logic        pop;
  logic        push_ok;
  logic        drop;
  logic        fifo_full;
  logic        fifo_empty;
  rec_t        wr_rec;
  rec_t        rd_rec;
  logic [REC_W-1:0] rd_flat;

  assign fire     = tl_if.d_valid & tl_if.d_ready;
  assign last_idx = beat_last_idx(tl_if.d_opcode, tl_if.d_size, LG_BYTES);
  assign is_last  = ({8'd0, beat_q} == last_idx);

  // Beat position follows every fire regardless of filtering.
  always_comb begin
    beat_d = beat_q;
    if (fire) beat_d = is_last ? 8'd0 : beat_q + 8'd1;
  end

  assign cand    = fire & cap_en_i & opcode_mask_i[tl_if.d_opcode];
  assign pop     = tl_if.rec_valid & tl_if.rec_ready;
  assign push_ok = cand & (~fifo_full | pop);
  assign drop    = cand & ~push_ok;

  always_comb begin
    drop_d = drop_q;
    ovf_d  = ovf_q;
    if (clear_i) begin
      drop_d = '0;
      ovf_d  = 1'b0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      beat_q <= '0;
      ts_q   <= '0;
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      beat_q <= beat_d;
      ts_q   <= ts_q + TS_W'(1);
      drop_q <= drop_d;
      ovf_q  <= ovf_d;
    end
  end

  always_comb begin
    wr_rec.opcode  = tl_if.d_opcode;
    wr_rec.param   = tl_if.d_param;
    wr_rec.source  = tl_if.d_source;
    wr_rec.sink    = tl_if.d_sink;
    wr_rec.denied  = tl_if.d_denied;
    wr_rec.corrupt = tl_if.d_corrupt;
    wr_rec.beat    = beat_q;
    wr_rec.last    = is_last;
    wr_rec.ts      = ts_q;
    wr_rec.data    = tl_if.d_data;
  end

  // clear also gates the push so a beat in the clearing cycle is discarded.
  scope_rec_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .flush_i   (clear_i),
    .push_i    (push_ok & ~clear_i),
    .wdata_i   (wr_rec),
    .pop_i     (pop),
    .rdata_o   (rd_flat),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign rd_rec = rec_t'(rd_flat);

  assign tl_if.rec_valid   = ~fifo_empty;
  assign tl_if.rec_opcode  = rd_rec.opcode;
  assign tl_if.rec_param   = rd_rec.param;
  assign tl_if.rec_source  = rd_rec.source;
  assign tl_if.rec_sink    = rd_rec.sink;
  assign tl_if.rec_denied  = rd_rec.denied;
  assign tl_if.rec_corrupt = rd_rec.corrupt;
  assign tl_if.rec_beat    = rd_rec.beat;
  assign tl_if.rec_last    = rd_rec.last;
  assign tl_if.rec_ts      = rd_rec.ts;
  assign tl_if.rec_data    = rd_rec.data;

  assign drop_cnt_o = drop_q;
  assign overflow_o = ovf_q;

endmodule
